// File: rtl/_arb_mux.sv
// Round-robin N:1 arbiter with a single registered output stage and valid/ready handshakes.
// Define ARB_MUX_FIXED_PRIO_EN for lowest-index-wins arbitration; WORD_LENGTH sets default width.

`ifndef WORD_LENGTH
`define WORD_LENGTH 16
`endif

module _arb_mux #(
  parameter int unsigned n  = `WORD_LENGTH,
  parameter int unsigned CH = 4,
  localparam int unsigned SW = $clog2(CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH-1:0]   in_valid,
  input  logic [CH*n-1:0] in_data,
  output logic [CH-1:0]   in_ready,
  output logic            out_valid,
  output logic [n-1:0]    out_data,
  output logic [SW-1:0]   out_sel,
  input  logic            out_ready
);

  logic          load;
  logic          xfer;
  logic          gnt_found;
  logic [SW-1:0] gnt_idx;
  logic [n-1:0]  gnt_data;

  logic          out_valid_q, out_valid_d;
  logic [n-1:0]  out_data_q, out_data_d;
  logic [SW-1:0] out_sel_q, out_sel_d;

  assign load = !out_valid_q || out_ready;
  assign xfer = load && gnt_found;

`ifdef ARB_MUX_FIXED_PRIO_EN

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      if (!gnt_found && in_valid[i]) begin
        gnt_found = 1'b1;
        gnt_idx   = SW'(i);
      end
    end
  end

`else

  logic [SW-1:0] ptr_q, ptr_d;
  int unsigned   cand;

  // Search starts just past the last winner so it drops to lowest priority.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int unsigned k = 1; k <= CH; k++) begin
      cand = 32'(ptr_q) + k;
      if (cand >= CH) cand = cand - CH;
      if (!gnt_found && in_valid[SW'(cand)]) begin
        gnt_found = 1'b1;
        gnt_idx   = SW'(cand);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) ptr_d = gnt_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= SW'(CH - 1);
    else     ptr_q <= ptr_d;
  end

`endif

  assign gnt_data = in_data[32'(gnt_idx)*n +: n];

  always_comb begin
    in_ready = '0;
    if (!rst && xfer) in_ready[gnt_idx] = 1'b1;
  end

  // Empty load clears valid but leaves data/sel as they were.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = gnt_data;
      out_sel_d   = gnt_idx;
    end else if (load) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb__arb_mux.sv
// Directed bench for _arb_mux (CH=4, n=16): per-cycle vector table plus a fairness sequence.

module tb__arb_mux;

  localparam int unsigned N  = 16;
  localparam int unsigned CH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    in_valid;
  logic [63:0]   in_data;
  logic [3:0]    in_ready;
  logic          out_valid;
  logic [15:0]   out_data;
  logic [1:0]    out_sel;
  logic          out_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  _arb_mux #(.n(N), .CH(CH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  // Inputs held for one cycle; expected in_ready for that cycle and register
  // contents as left by the previous edge.
  typedef struct {
    logic        rst;
    logic [3:0]  iv;
    logic        ordy;
    logic        chk_out;
    logic [3:0]  e_rdy;
    logic        e_v;
    logic [15:0] e_d;
    logic [1:0]  e_s;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

`ifdef ARB_MUX_FIXED_PRIO_EN
  localparam int NV = 8;
`else
  localparam int NV = 25;
`endif
  vec_t tbl [NV];

  int cnt [4];
  int nvalid;

  initial begin
`ifdef ARB_MUX_FIXED_PRIO_EN
    tbl[0] = '{1'b1, 4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0, 16'h0000, 2'd0};
    tbl[1] = '{1'b1, 4'b1010, 1'b1, 1'b1, 4'b0000, 1'b0, 16'h0000, 2'd0};
    tbl[2] = '{1'b0, 4'b1010, 1'b1, 1'b1, 4'b0010, 1'b0, 16'h0000, 2'd0};
    tbl[3] = '{1'b0, 4'b1010, 1'b1, 1'b1, 4'b0010, 1'b1, 16'hA001, 2'd1};
    tbl[4] = '{1'b0, 4'b1010, 1'b1, 1'b1, 4'b0010, 1'b1, 16'hA001, 2'd1};
    tbl[5] = '{1'b0, 4'b1010, 1'b1, 1'b1, 4'b0010, 1'b1, 16'hA001, 2'd1};
    tbl[6] = '{1'b0, 4'b1000, 1'b1, 1'b1, 4'b1000, 1'b1, 16'hA001, 2'd1};
    tbl[7] = '{1'b0, 4'b0000, 1'b1, 1'b1, 4'b0000, 1'b1, 16'hA003, 2'd3};
`else
    // reset, then first grant is channel 0
    tbl[0]  = '{1'b1, 4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0, 16'h0000, 2'd0};
    tbl[1]  = '{1'b1, 4'b1111, 1'b1, 1'b1, 4'b0000, 1'b0, 16'h0000, 2'd0};
    // round robin 0,1,2,3,0,1 with no bubbles
    tbl[2]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 4'b0001, 1'b0, 16'h0000, 2'd0};
    tbl[3]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 4'b0010, 1'b1, 16'hA000, 2'd0};
    tbl[4]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 4'b0100, 1'b1, 16'hA001, 2'd1};
    tbl[5]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 4'b1000, 1'b1, 16'hA002, 2'd2};
    tbl[6]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 4'b0001, 1'b1, 16'hA003, 2'd3};
    tbl[7]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 4'b0010, 1'b1, 16'hA000, 2'd0};
    // stall three cycles holding A001, then A002 follows
    tbl[8]  = '{1'b0, 4'b1111, 1'b0, 1'b1, 4'b0000, 1'b1, 16'hA001, 2'd1};
    tbl[9]  = '{1'b0, 4'b1111, 1'b0, 1'b1, 4'b0000, 1'b1, 16'hA001, 2'd1};
    tbl[10] = '{1'b0, 4'b1111, 1'b0, 1'b1, 4'b0000, 1'b1, 16'hA001, 2'd1};
    tbl[11] = '{1'b0, 4'b1111, 1'b1, 1'b1, 4'b0100, 1'b1, 16'hA001, 2'd1};
    // ptr=2, in_valid=0011: wrap to 0, then 1, then 0
    tbl[12] = '{1'b0, 4'b0011, 1'b1, 1'b1, 4'b0001, 1'b1, 16'hA002, 2'd2};
    tbl[13] = '{1'b0, 4'b0011, 1'b1, 1'b1, 4'b0010, 1'b1, 16'hA000, 2'd0};
    tbl[14] = '{1'b0, 4'b0011, 1'b1, 1'b1, 4'b0001, 1'b1, 16'hA001, 2'd1};
    // empty: valid drops, data/sel hold, ptr stays at 0
    tbl[15] = '{1'b0, 4'b0000, 1'b1, 1'b1, 4'b0000, 1'b1, 16'hA000, 2'd0};
    tbl[16] = '{1'b0, 4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 16'hA000, 2'd0};
    tbl[17] = '{1'b0, 4'b1111, 1'b1, 1'b1, 4'b0010, 1'b0, 16'hA000, 2'd0};
    // lone requester equal to ptr still wins every cycle
    tbl[18] = '{1'b0, 4'b0010, 1'b1, 1'b1, 4'b0010, 1'b1, 16'hA001, 2'd1};
    tbl[19] = '{1'b0, 4'b0010, 1'b1, 1'b1, 4'b0010, 1'b1, 16'hA001, 2'd1};
    // reset overrides a pending transfer; ptr returns to 3
    tbl[20] = '{1'b1, 4'b1111, 1'b1, 1'b1, 4'b0000, 1'b1, 16'hA001, 2'd1};
    tbl[21] = '{1'b0, 4'b0100, 1'b1, 1'b1, 4'b0100, 1'b0, 16'h0000, 2'd0};
    tbl[22] = '{1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b1, 16'hA002, 2'd2};
    tbl[23] = '{1'b0, 4'b0000, 1'b1, 1'b1, 4'b0000, 1'b1, 16'hA002, 2'd2};
    tbl[24] = '{1'b0, 4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 16'hA002, 2'd2};
`endif

    in_data   = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    rst       = 1'b1;
    in_valid  = '0;
    out_ready = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      rst       = tbl[i].rst;
      in_valid  = tbl[i].iv;
      out_ready = tbl[i].ordy;
      @(negedge clk);
      chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(tbl[i].e_rdy));
      if (tbl[i].chk_out) begin
        chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(tbl[i].e_v));
        chk($sformatf("v%0d out_data", i), 32'(out_data), 32'(tbl[i].e_d));
        chk($sformatf("v%0d out_sel", i), 32'(out_sel), 32'(tbl[i].e_s));
      end
    end

`ifndef ARB_MUX_FIXED_PRIO_EN
    // Fairness: all channels valid for 8 transfers -> each granted twice.
    @(posedge clk);
    #1;
    rst       = 1'b1;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) cnt[c] = 0;
    nvalid = 0;
    for (int cyc = 0; cyc < 9; cyc++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        nvalid++;
        cnt[out_sel]++;
      end
    end
    chk("fair total", 32'(nvalid), 32'd8);
    for (int c = 0; c < 4; c++) chk($sformatf("fair ch%0d", c), 32'(cnt[c]), 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
